// File: rtl/seg_display_sequencer_if.sv
// Request/result bundle between a display client and seg_display_sequencer.
// The master drives a binary value in; the slave returns BCD digits and the lit-digit mask.
interface seg_display_sequencer_if #(
   parameter int BIN_W      = 27,
   parameter int NUM_DIGITS = 8
);
   logic [BIN_W-1:0]        in_value;
   logic                    in_blank_lz;
   logic                    in_valid;
   logic                    in_ready;
   logic [4*NUM_DIGITS-1:0] bcd_out;
   logic [NUM_DIGITS-1:0]   turn_on;
   logic                    overflow;
   logic                    done;

   modport master (
      output in_value, in_blank_lz, in_valid,
      input  in_ready, bcd_out, turn_on, overflow, done
   );

   modport slave (
      input  in_value, in_blank_lz, in_valid,
      output in_ready, bcd_out, turn_on, overflow, done
   );
endinterface

// File: rtl/seg_display_sequencer.sv
// Sequential double-dabble binary-to-BCD converter with leading-zero blanking.
// Performs one shift per clock and holds the last complete result on its outputs.
module seg_display_sequencer #(
   parameter int BIN_W      = 27,
   parameter int NUM_DIGITS = 8
) (
   input  logic                      clock,
   input  logic                      reset,
   seg_display_sequencer_if.slave    bus
);
   localparam int BCD_W = 4 * NUM_DIGITS;
   localparam int CNT_W = $clog2(BIN_W + 1);

   function automatic logic [63:0] pow10(input int n);
      logic [63:0] p;
      p = 64'd1;
      for (int k = 0; k < n; k++) p = p * 64'd10;
      return p;
   endfunction

   localparam logic [63:0] MAX_VAL = pow10(NUM_DIGITS) - 64'd1;

   typedef enum logic [1:0] {S_IDLE, S_CONV, S_LATCH} state_t;

   state_t               r_state;
   logic [BIN_W-1:0]     r_shift;
   logic [BCD_W-1:0]     r_scratch;
   logic                 r_blank_lz;
   logic                 r_ovf;
   logic [CNT_W-1:0]     r_cnt;
   logic [BCD_W-1:0]     r_bcd;
   logic [NUM_DIGITS-1:0] r_turn_on;
   logic                 r_overflow;
   logic                 r_done;
   logic                 r_ready;

   logic [BCD_W-1:0]      w_adj;
   logic [NUM_DIGITS-1:0] w_lit;

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      w_adj = r_scratch;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (r_scratch[4*i +: 4] >= 4'd5) w_adj[4*i +: 4] = r_scratch[4*i +: 4] + 4'd3;
      end
   end

   // A digit is lit when it or any more-significant digit is nonzero; digit 0 always lit.
   always_comb begin
      logic w_any;
      w_any = 1'b0;
      w_lit = '0;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         w_any    = w_any | (|r_scratch[4*i +: 4]);
         w_lit[i] = w_any;
      end
      w_lit[0] = 1'b1;
   end

   // NOTE: all state uses non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_shift    <= '0;
         r_scratch  <= '0;
         r_blank_lz <= 1'b0;
         r_ovf      <= 1'b0;
         r_cnt      <= '0;
         r_bcd      <= '0;
         r_turn_on  <= NUM_DIGITS'(1);
         r_overflow <= 1'b0;
         r_done     <= 1'b0;
         r_ready    <= 1'b1;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (bus.in_valid) begin
                  r_shift    <= bus.in_value;
                  r_blank_lz <= bus.in_blank_lz;
                  r_scratch  <= '0;
                  r_ovf      <= 64'(bus.in_value) > MAX_VAL;
                  r_cnt      <= '0;
                  r_ready    <= 1'b0;
                  r_state    <= S_CONV;
               end
            end
            S_CONV: begin
               r_scratch <= {w_adj[BCD_W-2:0], r_shift[BIN_W-1]};
               r_shift   <= r_shift << 1;
               r_cnt     <= r_cnt + 1'b1;
               if (r_cnt == CNT_W'(BIN_W - 1)) r_state <= S_LATCH;
            end
            S_LATCH: begin
               if (r_ovf) begin
                  r_bcd      <= {NUM_DIGITS{4'h9}};
                  r_turn_on  <= '1;
                  r_overflow <= 1'b1;
               end else begin
                  r_bcd      <= r_scratch;
                  r_turn_on  <= r_blank_lz ? w_lit : '1;
                  r_overflow <= 1'b0;
               end
               r_done  <= 1'b1;
               r_ready <= 1'b1;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.in_ready = r_ready;
   assign bus.bcd_out  = r_bcd;
   assign bus.turn_on  = r_turn_on;
   assign bus.overflow = r_overflow;
   assign bus.done     = r_done;
endmodule
